execute_stage_mdu: RTL and testbench
====================================

Name: execute_stage_mdu

Overview:
- Next-generation EX stage of the RISC-V pipeline. Keeps operand forwarding, the ALU path, branch-target calculation and the EX/MEM pipeline register.
- Adds a parametrised multi-cycle multiply/divide unit (RV32M funct3 encoding) with a stall handshake to the hazard unit.
- Adds a synchronous flush that inserts a bubble into EX/MEM.
- Sits between the ID/EX register and the MEM stage. Instantiates the existing alu and mux3.

Parameters:
- DATA_WIDTH, 32, datapath width; divide iteration count.
- ADDR_WIDTH, 10, PC width.
- MUL_CYCLES, 2, busy cycles for a multiply (>=1).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset. Synchronous, active-low.
- i_rs1_data_e, i_rs2_data_e, i_immext_e  in  DATA_WIDTH  operands / sign-extended immediate.
- i_pc_e, i_pc4_e  in  ADDR_WIDTH  PC, PC+4.
- i_rd_addr_e  in  5  destination register.
- i_aluctrl_e  in  alu_op_t  ALU operation.
- i_alusrc_e, i_regwrite_e, i_memwrite_e  in  1  ALU B select (1=imm), RF write, memory write.
- i_resultsrc_e  in  2  result source.
- i_f3_e  in  3  funct3; also selects the MDU op.
- i_mdu_e  in  1  instruction is an M-extension op.
- i_flush_e  in  1  kill the EX instruction.
- i_forward_m, i_forward_w  in  DATA_WIDTH  forwarded data.
- i_forward_a, i_forward_b  in  2  forwarding select: 0=reg, 1=WB, 2=MEM.
- o_pctarget_e  out  ADDR_WIDTH  i_pc_e + i_immext_e, truncated.
- o_zero_e  out  1  ALU zero flag.
- o_stall_e  out  1  EX busy; hazard unit holds PC, IF/ID and ID/EX.
- o_alu_result_m, o_write_data_m  out  DATA_WIDTH  registered result / forwarded rs2.
- o_regwrite_m, o_memwrite_m  out  1  registered controls.
- o_resultsrc_m  out  2  registered result source.
- o_rd_addr_m  out  5  registered destination.
- o_pc4_m  out  ADDR_WIDTH  registered PC+4.
- o_f3_m  out  3  registered funct3.

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - All EX/MEM outputs 0, except o_f3_m=3'b010.
  - FSM goes to IDLE and the iteration counter clears.
  - o_stall_e=0 in the following cycle.
  - Reset mid-operation abandons the op; no result is written.
- Forwarding: operand A/B via mux3 on i_forward_a/b (3 is treated as 0). ALU B = i_alusrc_e ? imm : forwarded rs2.
- Non-MDU (i_mdu_e=0, IDLE): EX/MEM loads every posedge with the ALU result, forwarded rs2 and controls. Latency 1 cycle. o_stall_e=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with i_mdu_e=1 → accept:
    - Latch forwarded rs1/rs2 and funct3. Forwarding sources change during the stall, so latched values are used from here on.
    - o_stall_e=1 combinationally in the accept cycle.
    - EX/MEM loads a bubble: regwrite=0, memwrite=0, rd=0.
  - Multiply (f3[2]=0): IDLE → BUSY for MUL_CYCLES cycles → DONE.
  - Divide/remainder (f3[2]=1): IDLE → BUSY for DATA_WIDTH cycles of radix-2 restoring iteration on magnitudes, sign fix-up at DONE → DONE.
  - Divide special cases go IDLE → DONE directly (stall 1 cycle):
    - Divisor 0: DIV/DIVU = all ones; REM/REMU = dividend.
    - Signed overflow (most-negative / −1): DIV = dividend; REM = 0.
  - DONE: o_stall_e=0. At that posedge EX/MEM loads the MDU result with the held ID/EX controls. FSM → IDLE.
  - A back-to-back MDU op in the next cycle is accepted normally.
- Result selection by funct3, from a 2·DATA_WIDTH product of operands sign/zero-extended:
  - 000 MUL = low half.
  - 001 MULH = high half, signed×signed.
  - 010 MULHSU = high half, signed×unsigned.
  - 011 MULHU = high half, unsigned×unsigned.
  - 100 DIV, 101 DIVU = quotient.
  - 110 REM, 111 REMU = remainder; remainder sign follows the dividend.
- Stall cycles:
  - MUL: MUL_CYCLES+1.
  - DIV: DATA_WIDTH+1.
  - Special divide: 1.
- Flush (i_flush_e=1 at posedge) has priority over everything except reset:
  - EX/MEM loads a bubble (all controls 0, o_f3_m=3'b010).
  - FSM → IDLE and any MDU op is abandoned.
  - o_stall_e is forced 0 in that cycle.
- o_pctarget_e and o_zero_e stay combinational, even while stalled.

Test Plan:
- Reset: drive i_rst_n=0 for 2 clocks mid-DIV → next cycle all outputs 0, o_f3_m=3'b010, o_stall_e=0.
- ADD x5, rs1=7, rs2=5, forward_a=2, i_forward_m=100, alusrc=0 → one cycle later o_alu_result_m=105, o_rd_addr_m=5, regwrite=1.
- MULH (f3=001), −2 × 3, MUL_CYCLES=2 → o_stall_e high 3 cycles; then o_alu_result_m=0xFFFFFFFF. MUL (f3=000) gives 0xFFFFFFFA. No regwrite bubble leaks.
- DIV (f3=100), −7 / 2 → stall 33 cycles, quotient 0xFFFFFFFD. REM (f3=110) gives 0xFFFFFFFF.
- DIVU by 0, dividend 9 → stall 1 cycle, result 0xFFFFFFFF. REMU gives 9. DIV 0x80000000 / −1 → 0x80000000.
- Assert i_flush_e at BUSY cycle 10 of a DIV → next cycle o_regwrite_m=0, o_stall_e=0, FSM IDLE. A following ADD completes in 1 cycle.

Source files
------------

// File: rtl/execute_stage_mdu.sv
// EX stage: forwarding, ALU, branch target, EX/MEM register,
// plus an iterative RV32M multiply/divide unit that stalls the front end.
package execute_stage_mdu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;
endpackage

module mux3 #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_d0,
    input  logic [W-1:0] i_d1,
    input  logic [W-1:0] i_d2,
    input  logic [1:0]   i_sel,
    output logic [W-1:0] o_y
);
    // Select 3 is unused by the hazard unit and falls back to d0
    always_comb begin
        case (i_sel)
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            default: o_y = i_d0;
        endcase
    end
endmodule

module alu
    import execute_stage_mdu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [3:0]   i_op,
    output logic [W-1:0] o_y,
    output logic         o_zero
);
    localparam int SW = $clog2(W);

    // Integer operations of the base ISA
    always_comb begin
        o_y = '0;
        case (i_op)
            ALU_ADD:   o_y = i_a + i_b;
            ALU_SUB:   o_y = i_a - i_b;
            ALU_AND:   o_y = i_a & i_b;
            ALU_OR:    o_y = i_a | i_b;
            ALU_XOR:   o_y = i_a ^ i_b;
            ALU_SLL:   o_y = i_a << i_b[SW-1:0];
            ALU_SRL:   o_y = i_a >> i_b[SW-1:0];
            ALU_SRA:   o_y = $signed(i_a) >>> i_b[SW-1:0];
            ALU_SLT:   o_y = {{(W-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            ALU_SLTU:  o_y = {{(W-1){1'b0}}, i_a < i_b};
            ALU_PASSB: o_y = i_b;
            default:   o_y = '0;
        endcase
    end

    assign o_zero = (o_y == '0);
endmodule

module execute_stage_mdu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MUL_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rs1_data_e,
    input  logic [DATA_WIDTH-1:0] i_rs2_data_e,
    input  logic [DATA_WIDTH-1:0] i_immext_e,
    input  logic [ADDR_WIDTH-1:0] i_pc_e,
    input  logic [ADDR_WIDTH-1:0] i_pc4_e,
    input  logic [4:0]            i_rd_addr_e,
    input  logic [3:0]            i_aluctrl_e,
    input  logic                  i_alusrc_e,
    input  logic                  i_regwrite_e,
    input  logic                  i_memwrite_e,
    input  logic [1:0]            i_resultsrc_e,
    input  logic [2:0]            i_f3_e,
    input  logic                  i_mdu_e,
    input  logic                  i_flush_e,
    input  logic [DATA_WIDTH-1:0] i_forward_m,
    input  logic [DATA_WIDTH-1:0] i_forward_w,
    input  logic [1:0]            i_forward_a,
    input  logic [1:0]            i_forward_b,
    output logic [ADDR_WIDTH-1:0] o_pctarget_e,
    output logic                  o_zero_e,
    output logic                  o_stall_e,
    output logic [DATA_WIDTH-1:0] o_alu_result_m,
    output logic [DATA_WIDTH-1:0] o_write_data_m,
    output logic                  o_regwrite_m,
    output logic                  o_memwrite_m,
    output logic [1:0]            o_resultsrc_m,
    output logic [4:0]            o_rd_addr_m,
    output logic [ADDR_WIDTH-1:0] o_pc4_m,
    output logic [2:0]            o_f3_m
);
    localparam int W    = DATA_WIDTH;
    localparam int MAXC = (W > MUL_CYCLES) ? W : MUL_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(W - 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [W-1:0]  W_MIN    = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_a, r_b, r_quot, r_rem, r_dvs, r_spec_res;
    logic [2:0]      r_f3;
    logic            r_special;
    logic [W-1:0]    r_alu_result_m, r_write_data_m;
    logic            r_regwrite_m, r_memwrite_m;
    logic [1:0]      r_resultsrc_m;
    logic [4:0]      r_rd_addr_m;
    logic [ADDR_WIDTH-1:0] r_pc4_m;
    logic [2:0]      r_f3_m;

    logic [W-1:0]    w_src_a, w_src_b, w_alu_b, w_alu_y;
    logic            w_stall, w_accept, w_sgn_in, w_div0, w_ovf, w_special;
    logic [W-1:0]    w_spec_res, w_abs_a, w_abs_b;
    logic [W:0]      w_shift, w_trial;
    logic            w_last, w_a_sgn, w_b_sgn, w_neg_q, w_neg_r;
    logic [2*W-1:0]  w_opa_ext, w_opb_ext, w_prod;
    logic [W-1:0]    w_mdu_res;

    mux3 #(.W(W)) u_fwd_a (
        .i_d0(i_rs1_data_e), .i_d1(i_forward_w), .i_d2(i_forward_m),
        .i_sel(i_forward_a), .o_y(w_src_a)
    );
    mux3 #(.W(W)) u_fwd_b (
        .i_d0(i_rs2_data_e), .i_d1(i_forward_w), .i_d2(i_forward_m),
        .i_sel(i_forward_b), .o_y(w_src_b)
    );

    assign w_alu_b = i_alusrc_e ? i_immext_e : w_src_b;

    alu #(.W(W)) u_alu (
        .i_a(w_src_a), .i_b(w_alu_b), .i_op(i_aluctrl_e),
        .o_y(w_alu_y), .o_zero(o_zero_e)
    );

    assign o_pctarget_e = i_pc_e + i_immext_e[ADDR_WIDTH-1:0];

    // Divide operand conditioning and special cases at accept time
    assign w_sgn_in  = ~i_f3_e[0];
    assign w_div0    = (w_src_b == '0);
    assign w_ovf     = w_sgn_in && (w_src_a == W_MIN) && (w_src_b == '1);
    assign w_special = i_f3_e[2] && (w_div0 || w_ovf);
    assign w_spec_res = w_div0 ? (i_f3_e[1] ? w_src_a : '1)
                               : (i_f3_e[1] ? '0 : w_src_a);
    assign w_abs_a = (w_sgn_in && w_src_a[W-1]) ? -w_src_a : w_src_a;
    assign w_abs_b = (w_sgn_in && w_src_b[W-1]) ? -w_src_b : w_src_b;
    assign w_accept = (r_state == S_IDLE) && i_mdu_e && !i_flush_e;
    assign w_last   = (r_cnt == (r_f3[2] ? DIV_LAST : MUL_LAST));

    // One restoring-division step on magnitudes
    assign w_shift = {r_rem, r_quot[W-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    // FSM next state and stall; flush wins over any MDU activity
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        unique case (r_state)
            S_IDLE: if (i_mdu_e) begin
                w_stall = 1'b1;
                w_next  = w_special ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_flush_e) begin
            w_next  = S_IDLE;
            w_stall = 1'b0;
        end
    end

    assign o_stall_e = w_stall;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Operand latch, iteration counter and divider datapath
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a        <= w_src_a;
            r_b        <= w_src_b;
            r_f3       <= i_f3_e;
            r_cnt      <= '0;
            r_quot     <= w_abs_a;
            r_dvs      <= w_abs_b;
            r_rem      <= '0;
            r_special  <= w_special;
            r_spec_res <= w_spec_res;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_f3[2]) begin
                if (!w_trial[W]) begin
                    r_rem  <= w_trial[W-1:0];
                    r_quot <= {r_quot[W-2:0], 1'b1};
                end else begin
                    r_rem  <= w_shift[W-1:0];
                    r_quot <= {r_quot[W-2:0], 1'b0};
                end
            end
        end
    end

    // Product of sign/zero-extended latched operands
    assign w_a_sgn   = (r_f3[1:0] == 2'b01) || (r_f3[1:0] == 2'b10);
    assign w_b_sgn   = (r_f3[1:0] == 2'b01);
    assign w_opa_ext = {{W{r_a[W-1] & w_a_sgn}}, r_a};
    assign w_opb_ext = {{W{r_b[W-1] & w_b_sgn}}, r_b};
    assign w_prod    = w_opa_ext * w_opb_ext;
    assign w_neg_q   = ~r_f3[0] & (r_a[W-1] ^ r_b[W-1]);
    assign w_neg_r   = ~r_f3[0] & r_a[W-1];

    // MDU result selection with sign fix-up
    always_comb begin
        w_mdu_res = w_prod[W-1:0];
        case (r_f3)
            3'b000:                 w_mdu_res = w_prod[W-1:0];
            3'b001, 3'b010, 3'b011: w_mdu_res = w_prod[2*W-1:W];
            3'b100, 3'b101:         w_mdu_res = w_neg_q ? -r_quot : r_quot;
            default:                w_mdu_res = w_neg_r ? -r_rem : r_rem;
        endcase
        if (r_special) w_mdu_res = r_spec_res;
    end

    // EX/MEM register: bubble on reset/flush/stall, MDU result at DONE
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush_e || w_stall) begin
            r_alu_result_m <= '0;
            r_write_data_m <= '0;
            r_regwrite_m   <= 1'b0;
            r_memwrite_m   <= 1'b0;
            r_resultsrc_m  <= 2'b00;
            r_rd_addr_m    <= 5'd0;
            r_pc4_m        <= '0;
            r_f3_m         <= 3'b010;
        end else begin
            r_regwrite_m  <= i_regwrite_e;
            r_memwrite_m  <= i_memwrite_e;
            r_resultsrc_m <= i_resultsrc_e;
            r_rd_addr_m   <= i_rd_addr_e;
            r_pc4_m       <= i_pc4_e;
            if (r_state == S_DONE) begin
                r_alu_result_m <= w_mdu_res;
                r_write_data_m <= r_b;
                r_f3_m         <= r_f3;
            end else begin
                r_alu_result_m <= w_alu_y;
                r_write_data_m <= w_src_b;
                r_f3_m         <= i_f3_e;
            end
        end
    end

    assign o_alu_result_m = r_alu_result_m;
    assign o_write_data_m = r_write_data_m;
    assign o_regwrite_m   = r_regwrite_m;
    assign o_memwrite_m   = r_memwrite_m;
    assign o_resultsrc_m  = r_resultsrc_m;
    assign o_rd_addr_m    = r_rd_addr_m;
    assign o_pc4_m        = r_pc4_m;
    assign o_f3_m         = r_f3_m;
endmodule

// File: tb/tb_execute_stage_mdu.sv
// Randomized bench for execute_stage_mdu against an
// arithmetic reference model of the ALU and RV32M ops.
module tb_execute_stage_mdu;
    import execute_stage_mdu_pkg::*;

    localparam int W  = 32;
    localparam int AW = 10;
    localparam int MC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  rs1, rs2, imm, fwd_m, fwd_w;
    logic [AW-1:0] pc, pc4;
    logic [4:0]    rd;
    logic [3:0]    aluctrl;
    logic          alusrc, regwrite, memwrite, mdu, flush;
    logic [1:0]    resultsrc, fa, fb;
    logic [2:0]    f3;
    logic [AW-1:0] pctarget;
    logic          zero, stall;
    logic [W-1:0]  res_m, wd_m;
    logic          regwrite_m, memwrite_m;
    logic [1:0]    resultsrc_m;
    logic [4:0]    rd_m;
    logic [AW-1:0] pc4_m;
    logic [2:0]    f3_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    execute_stage_mdu #(
        .DATA_WIDTH(W), .ADDR_WIDTH(AW), .MUL_CYCLES(MC)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs1_data_e(rs1), .i_rs2_data_e(rs2), .i_immext_e(imm),
        .i_pc_e(pc), .i_pc4_e(pc4), .i_rd_addr_e(rd),
        .i_aluctrl_e(aluctrl), .i_alusrc_e(alusrc),
        .i_regwrite_e(regwrite), .i_memwrite_e(memwrite),
        .i_resultsrc_e(resultsrc), .i_f3_e(f3), .i_mdu_e(mdu),
        .i_flush_e(flush), .i_forward_m(fwd_m), .i_forward_w(fwd_w),
        .i_forward_a(fa), .i_forward_b(fb),
        .o_pctarget_e(pctarget), .o_zero_e(zero), .o_stall_e(stall),
        .o_alu_result_m(res_m), .o_write_data_m(wd_m),
        .o_regwrite_m(regwrite_m), .o_memwrite_m(memwrite_m),
        .o_resultsrc_m(resultsrc_m), .o_rd_addr_m(rd_m),
        .o_pc4_m(pc4_m), .o_f3_m(f3_m)
    );

    function automatic logic [W-1:0] fwd(input logic [1:0] s,
                                         input logic [W-1:0] r);
        if (s == 2'd1) return fwd_w;
        if (s == 2'd2) return fwd_m;
        return r;
    endfunction

    function automatic logic [W-1:0] alu_ref(input logic [3:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLL:   return a << b[4:0];
            ALU_SRL:   return a >> b[4:0];
            ALU_SRA:   return sa >>> b[4:0];
            ALU_SLT:   return (sa < sb) ? 1 : 0;
            ALU_SLTU:  return (a < b) ? 1 : 0;
            ALU_PASSB: return b;
            default:   return 0;
        endcase
    endfunction

    function automatic logic [W-1:0] mdu_ref(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, ua, ub, p;
        int ia, ib;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int stall_ref(input logic [2:0] op,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        if (!op[2]) return MC + 1;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return W + 1;
    endfunction

    task automatic idle_inputs();
        rs1 = 0; rs2 = 0; imm = 0; fwd_m = 0; fwd_w = 0;
        pc = 0; pc4 = 0; rd = 0; aluctrl = 0;
        alusrc = 0; regwrite = 0; memwrite = 0; mdu = 0;
        flush = 0; resultsrc = 0; fa = 0; fb = 0; f3 = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (res_m !== 0 || wd_m !== 0 || regwrite_m !== 0 ||
            memwrite_m !== 0 || resultsrc_m !== 0 || rd_m !== 0 ||
            pc4_m !== 0 || f3_m !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_regs: res=%h wd=%h rw=%b mw=%b rs=%h rd=%0d pc4=%h f3=%b, need zeros f3=010",
                     res_m, wd_m, regwrite_m, memwrite_m,
                     resultsrc_m, rd_m, pc4_m, f3_m);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b need 0", stall);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_div();
        mdu = 1; f3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd7;
        regwrite = 1; rd = 5'd9;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 0; mdu = 0; regwrite = 0; rd = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        n_checks++;
        if (regwrite_m !== 0 || rd_m !== 0 || res_m !== 0 ||
            f3_m !== 3'b010 || stall !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_div: rw=%b rd=%0d res=%h f3=%b stall=%b, need 0/0/0/010/0",
                     regwrite_m, rd_m, res_m, f3_m, stall);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (regwrite_m !== 0 || stall !== 0) begin
            n_fail++;
            $display("FAIL reset_no_result: rw=%b stall=%b need 0/0",
                     regwrite_m, stall);
        end
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [1:0] sa,
                          input logic [1:0] sb, input logic src);
        logic [W-1:0]  a, b, eb, ey;
        logic [AW-1:0] ept;
        logic [4:0]    erd;
        logic          erw, emw;
        logic [1:0]    ers;
        logic [2:0]    ef3;
        logic [AW-1:0] epc4;
        mdu = 0; aluctrl = op; fa = sa; fb = sb; alusrc = src;
        a   = fwd(fa, rs1);
        eb  = fwd(fb, rs2);
        b   = alusrc ? imm : eb;
        ey  = alu_ref(op, a, b);
        ept = pc + imm[AW-1:0];
        erd = rd; erw = regwrite; emw = memwrite;
        ers = resultsrc; ef3 = f3; epc4 = pc4;
        #1;
        n_checks++;
        if (zero !== (ey == 0) || pctarget !== ept || stall !== 0) begin
            n_fail++;
            $display("FAIL alu_comb op=%0d: zero=%b pct=%h stall=%b, need %b %h 0",
                     op, zero, pctarget, stall, (ey == 0), ept);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (res_m !== ey || wd_m !== eb || rd_m !== erd ||
            regwrite_m !== erw || memwrite_m !== emw ||
            resultsrc_m !== ers || f3_m !== ef3 || pc4_m !== epc4) begin
            n_fail++;
            $display("FAIL alu_reg op=%0d: res=%h wd=%h rd=%0d rw=%b mw=%b rs=%0d f3=%0d pc4=%h, need %h %h %0d %b %b %0d %0d %h",
                     op, res_m, wd_m, rd_m, regwrite_m, memwrite_m,
                     resultsrc_m, f3_m, pc4_m, ey, eb, erd, erw, emw,
                     ers, ef3, epc4);
        end
    endtask

    task automatic test_add();
        rs1 = 7; rs2 = 5; fwd_m = 100; fwd_w = 0; imm = 0;
        rd = 5; regwrite = 1; memwrite = 0; resultsrc = 0;
        f3 = 0; pc = 10'h40; pc4 = 10'h44;
        alu_op(ALU_ADD, 2'd2, 2'd0, 1'b0);
        n_checks++;
        if (res_m !== 32'd105 || rd_m !== 5'd5 || regwrite_m !== 1) begin
            n_fail++;
            $display("FAIL add_fwd: res=%0d rd=%0d rw=%b need 105 5 1",
                     res_m, rd_m, regwrite_m);
        end
    endtask

    task automatic test_alu_random();
        for (int k = 0; k < 24; k++) begin
            rs1 = $urandom; rs2 = $urandom; imm = $urandom;
            fwd_m = $urandom; fwd_w = $urandom;
            if (k % 4 == 0) rs2 = rs1;
            pc = AW'($urandom); pc4 = AW'($urandom);
            rd = 5'($urandom); regwrite = 1'($urandom);
            memwrite = 1'($urandom); resultsrc = 2'($urandom);
            f3 = 3'($urandom);
            alu_op(4'($urandom_range(0, 10)),
                   (k % 4 == 0) ? 2'd0 : 2'($urandom_range(0, 3)),
                   (k % 4 == 0) ? 2'd0 : 2'($urandom_range(0, 3)),
                   (k % 4 == 0) ? 1'b0 : 1'($urandom));
        end
    endtask

    task automatic run_mdu(input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [4:0] dst);
        logic [W-1:0] ea, eb, er;
        int est, nst;
        logic leak;
        mdu = 1; f3 = op; regwrite = 1; memwrite = 0; resultsrc = 0;
        alusrc = 0; aluctrl = ALU_ADD; rd = dst;
        fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
        fwd_m = $urandom; fwd_w = $urandom;
        rs1 = $urandom; rs2 = $urandom;
        if (fa == 2'd1) fwd_w = a;
        else if (fa == 2'd2) fwd_m = a;
        else rs1 = a;
        if (fb == 2'd1) fwd_w = b;
        else if (fb == 2'd2) fwd_m = b;
        else rs2 = b;
        ea = fwd(fa, rs1);
        eb = fwd(fb, rs2);
        er = mdu_ref(op, ea, eb);
        est = stall_ref(op, ea, eb);
        nst = 0;
        leak = 0;
        #1;
        while (stall === 1'b1 && nst < 100) begin
            nst++;
            @(posedge clk);
            #1;
            if (regwrite_m !== 0 || rd_m !== 0) leak = 1;
            fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
            fwd_m = $urandom; fwd_w = $urandom;
            #1;
        end
        n_checks++;
        if (nst != est || leak) begin
            n_fail++;
            $display("FAIL mdu_stall f3=%0d a=%h b=%h: stalls=%0d leak=%b, need %0d 0",
                     op, ea, eb, nst, leak, est);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (res_m !== er || rd_m !== dst || regwrite_m !== 1 ||
            f3_m !== op || wd_m !== eb) begin
            n_fail++;
            $display("FAIL mdu_result f3=%0d a=%h b=%h: res=%h rd=%0d rw=%b f3=%0d wd=%h, need %h %0d 1 %0d %h",
                     op, ea, eb, res_m, rd_m, regwrite_m, f3_m, wd_m,
                     er, dst, op, eb);
        end
    endtask

    task automatic end_mdu();
        mdu = 0; regwrite = 0; rd = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        run_mdu(3'b001, 32'hFFFF_FFFE, 32'd3, 5'd6);
        n_checks++;
        if (res_m !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL mulh_plan: got %h need ffffffff", res_m);
        end
        end_mdu();
        run_mdu(3'b000, 32'hFFFF_FFFE, 32'd3, 5'd7);
        n_checks++;
        if (res_m !== 32'hFFFF_FFFA) begin
            n_fail++;
            $display("FAIL mul_plan: got %h need fffffffa", res_m);
        end
        end_mdu();
        for (int k = 0; k < 12; k++) begin
            run_mdu(3'($urandom_range(0, 3)), $urandom, $urandom,
                    5'($urandom_range(1, 31)));
            end_mdu();
        end
    endtask

    task automatic test_div();
        run_mdu(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8);
        n_checks++;
        if (res_m !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_plan: got %h need fffffffd", res_m);
        end
        end_mdu();
        run_mdu(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8);
        n_checks++;
        if (res_m !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL rem_plan: got %h need ffffffff", res_m);
        end
        end_mdu();
        for (int k = 0; k < 10; k++) begin
            logic [W-1:0] dv;
            dv = (k % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (k % 3 == 0) dv = -dv;
            run_mdu(3'($urandom_range(4, 7)), $urandom, dv,
                    5'($urandom_range(1, 31)));
            end_mdu();
        end
    endtask

    task automatic test_div_special();
        run_mdu(3'b101, 32'd9, 32'd0, 5'd3);
        end_mdu();
        run_mdu(3'b111, 32'd9, 32'd0, 5'd3);
        end_mdu();
        run_mdu(3'b100, 32'd9, 32'd0, 5'd3);
        end_mdu();
        run_mdu(3'b110, 32'hDEAD_BEEF, 32'd0, 5'd3);
        end_mdu();
        run_mdu(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        end_mdu();
        run_mdu(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        end_mdu();
        run_mdu(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        end_mdu();
    endtask

    task automatic test_back_to_back();
        run_mdu(3'b011, $urandom, $urandom, 5'd11);
        run_mdu(3'b100, $urandom, 32'd13, 5'd12);
        run_mdu(3'b101, 32'd5, 32'd0, 5'd13);
        run_mdu(3'b000, $urandom, $urandom, 5'd14);
        end_mdu();
    endtask

    task automatic test_flush();
        mdu = 1; f3 = 3'b100; rs1 = 32'd12345; rs2 = 32'd17;
        fa = 0; fb = 0; regwrite = 1; rd = 5'd21;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        flush = 1;
        #1;
        n_checks++;
        if (stall !== 0) begin
            n_fail++;
            $display("FAIL flush_stall_comb: got %b need 0", stall);
        end
        @(posedge clk);
        #1;
        flush = 0; mdu = 0; regwrite = 0; rd = 0;
        #1;
        n_checks++;
        if (regwrite_m !== 0 || rd_m !== 0 || f3_m !== 3'b010 ||
            stall !== 0) begin
            n_fail++;
            $display("FAIL flush_bubble: rw=%b rd=%0d f3=%b stall=%b, need 0 0 010 0",
                     regwrite_m, rd_m, f3_m, stall);
        end
        rs1 = 32'd40; rs2 = 32'd2; fwd_m = 0; fwd_w = 0;
        rd = 5'd22; regwrite = 1; f3 = 3'b000; imm = 0;
        alu_op(ALU_ADD, 2'd0, 2'd0, 1'b0);
        n_checks++;
        if (res_m !== 32'd42 || rd_m !== 5'd22) begin
            n_fail++;
            $display("FAIL flush_then_add: res=%0d rd=%0d need 42 22",
                     res_m, rd_m);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_random();
        test_mul();
        test_div();
        test_div_special();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
